// File: rtl/npc_bpred.sv
// npc_bpred: fetch-stage next-PC generator with a direct-mapped BTB and
// 2-bit saturating direction counters.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   stall                hold the fetch PC
//   redirect/redirect_pc correction from execute (overrides stall)
//   pc                   registered fetch PC (word address)
//   pred_taken           lookup of pc predicts a taken transfer
//   pred_target          predicted next PC for pc (combinational)
//   res_*                resolve/training port from execute
//   branch_cnt           saturating count of resolved transfers
//   mispred_cnt          saturating count of mispredictions
module npc_bpred #(
    parameter int unsigned     PC_W     = 30,
    parameter int unsigned     IDX_W    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect,
    input  logic [PC_W-1:0]  redirect_pc,
    output logic [PC_W-1:0]  pc,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             res_valid,
    input  logic [PC_W-1:0]  res_pc,
    input  logic             res_cond,
    input  logic             res_taken,
    input  logic [PC_W-1:0]  res_target,
    input  logic             res_mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;
    localparam int unsigned TAG_W   = PC_W - IDX_W;

    logic [PC_W-1:0]  r_pc;
    logic             r_valid  [ENTRIES];
    logic [TAG_W-1:0] r_tag    [ENTRIES];
    logic [PC_W-1:0]  r_target [ENTRIES];
    logic             r_uncond [ENTRIES];
    logic [1:0]       r_ctr    [ENTRIES];
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    // Lookup
    logic [IDX_W-1:0] w_idx;
    logic             w_hit;
    logic [PC_W-1:0]  w_pc_inc;

    assign w_idx    = r_pc[IDX_W-1:0];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == r_pc[PC_W-1:IDX_W]);
    assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

    assign pred_taken  = w_hit && (r_uncond[w_idx] || r_ctr[w_idx][1]);
    assign pred_target = pred_taken ? r_target[w_idx] : w_pc_inc;
    assign pc          = r_pc;
    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;

    // Training: compute the replacement entry from the current (old) contents
    logic [IDX_W-1:0] w_res_idx;
    logic             w_res_hit;
    logic             w_wr_en;
    logic [PC_W-1:0]  w_new_target;
    logic             w_new_uncond;
    logic [1:0]       w_new_ctr;

    assign w_res_idx = res_pc[IDX_W-1:0];
    assign w_res_hit = r_valid[w_res_idx] && (r_tag[w_res_idx] == res_pc[PC_W-1:IDX_W]);

    always_comb begin
        w_wr_en      = 1'b0;
        w_new_target = r_target[w_res_idx];
        w_new_uncond = r_uncond[w_res_idx];
        w_new_ctr    = r_ctr[w_res_idx];
        if (res_valid) begin
            if (w_res_hit) begin
                w_wr_en = 1'b1;
                if (res_cond) begin
                    if (res_taken) begin
                        w_new_target = res_target;
                        if (r_ctr[w_res_idx] != 2'd3) begin
                            w_new_ctr = r_ctr[w_res_idx] + 2'd1;
                        end
                    end else if (r_ctr[w_res_idx] != 2'd0) begin
                        w_new_ctr = r_ctr[w_res_idx] - 2'd1;
                    end
                end else begin
                    w_new_target = res_target;
                    w_new_uncond = 1'b1;
                    w_new_ctr    = 2'd3;
                end
            end else if (res_taken) begin
                // Miss: allocate over whatever aliases at this index
                w_wr_en      = 1'b1;
                w_new_target = res_target;
                w_new_uncond = !res_cond;
                w_new_ctr    = res_cond ? 2'd2 : 2'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_uncond[i] <= 1'b0;
                r_ctr[i]    <= 2'd0;
            end
        end else begin
            if (redirect) begin
                r_pc <= redirect_pc;
            end else if (!stall) begin
                r_pc <= pred_target;
            end

            if (w_wr_en) begin
                r_valid[w_res_idx]  <= 1'b1;
                r_tag[w_res_idx]    <= res_pc[PC_W-1:IDX_W];
                r_target[w_res_idx] <= w_new_target;
                r_uncond[w_res_idx] <= w_new_uncond;
                r_ctr[w_res_idx]    <= w_new_ctr;
            end

            if (res_valid && (r_branch_cnt != {CNT_W{1'b1}})) begin
                r_branch_cnt <= r_branch_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (res_valid && res_mispredict && (r_mispred_cnt != {CNT_W{1'b1}})) begin
                r_mispred_cnt <= r_mispred_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
